// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request/response bundle between the requesters and the shared-adder arbiter
interface adder_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int IDW     = 1
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_data;
  logic                     resp_ready;
  logic [IDW-1:0]           grant_id;
  logic                     busy;

  // requester/consumer side
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, grant_id, busy
  );

  // arbiter side
  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, grant_id, busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one combinational adder between requesters
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result
);
  // carry-out is intentionally discarded: arithmetic is modulo 2^WIDTH
  assign result = data1 + data2;
endmodule

module adder_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int IDW     = 1
) (
  input  logic            clk,
  input  logic            rst,
  adder_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);

  state_t             state, next_state;
  logic [IDW-1:0]     rr_ptr, rr_next;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     sel_idx;
  logic               sel_found;
  logic [IDW:0]       cand;
  logic [IDW:0]       ptr_inc;
  logic               accept;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   resp_data;

  // the single shared adder only ever sees the latched operands
  adder #(.WIDTH(WIDTH)) u_adder (
    .data1  (op_a),
    .data2  (op_b),
    .result (sum)
  );

  // round-robin pick: first currently-valid index at or after rr_ptr, wrapping
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (IDW+1)'(rr_ptr) + (IDW+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!sel_found && bus.req_valid[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
    ptr_inc = (IDW+1)'(sel_idx) + (IDW+1)'(1);
    if (ptr_inc >= NUM_REQ_W) ptr_inc = '0;
    rr_next = ptr_inc[IDW-1:0];
  end

  // state register; reset drops any in-flight result at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // next-state and grant; req_ready is held low while reset is asserted
  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found && !rst) begin
          req_ready  = NUM_REQ'(1) << sel_idx;
          accept     = 1'b1;
          next_state = CALC;
        end
      end
      CALC: next_state = RESP;
      RESP: if (bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // operand capture at grant, sum registered in the single CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      resp_data <= '0;
    end else begin
      if (accept) begin
        op_a     <= bus.req_a[int'(sel_idx)*WIDTH +: WIDTH];
        op_b     <= bus.req_b[int'(sel_idx)*WIDTH +: WIDTH];
        grant_id <= sel_idx;
        rr_ptr   <= rr_next;
      end
      if (state == CALC) resp_data <= sum;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.resp_data  = resp_data;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized and directed checks of adder_arbiter against a transaction model
module tb_adder_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .IDW(IW)) bus ();

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // model: one operation in flight at most; response due two cycles after accept
  bit         m_busy;
  int         m_ptr, m_tag, m_cycle, m_acc_cycle;
  logic [W-1:0] m_sum;

  int           obs_tag[$];
  logic [W-1:0] obs_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_tag = 0; m_cycle = 0; m_acc_cycle = 0; m_sum = '0;
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  // called at posedge+1 with inputs already driven; returns at the next posedge+1
  task automatic step();
    int pick;
    logic [N-1:0] exp_rdy, exp_rv;
    #1;
    pick    = m_busy ? -1 : first_from(bus.req_valid, m_ptr);
    exp_rdy = (pick >= 0) ? (N'(1) << pick) : '0;
    exp_rv  = (m_busy && m_cycle >= m_acc_cycle + 2) ? (N'(1) << m_tag) : '0;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
    check("busy", 64'(bus.busy), 64'(m_busy));
    check("grant_id", 64'(bus.grant_id), 64'(m_tag));
    if (exp_rv != 0) check("resp_data", 64'(bus.resp_data), 64'(m_sum));
    if (bus.resp_valid != 0 && bus.resp_ready) begin
      obs_tag.push_back(onehot_idx(bus.resp_valid));
      obs_data.push_back(bus.resp_data);
    end
    @(posedge clk);
    if (pick >= 0) begin
      m_busy      = 1;
      m_tag       = pick;
      m_acc_cycle = m_cycle;
      m_sum       = bus.req_a[pick*W +: W] + bus.req_b[pick*W +: W];
      m_ptr       = (pick + 1) % N;
    end else if (exp_rv != 0 && bus.resp_ready) begin
      m_busy = 0;
    end
    m_cycle++;
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_resp_data", 64'(bus.resp_data), 64'd0);
    check("rst_grant_id", 64'(bus.grant_id), 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    obs_tag.delete();
    obs_data.delete();
  endtask

  task automatic check_obs(input string tag, input int idx, input int exp_tag, input logic [W-1:0] exp_data);
    int           t;
    logic [W-1:0] d;
    t = (idx < obs_tag.size()) ? obs_tag[idx] : -1;
    d = (idx < obs_data.size()) ? obs_data[idx] : 'x;
    check({tag, "_tag"}, 64'(t), 64'(exp_tag));
    check({tag, "_data"}, 64'(d), 64'(exp_data));
  endtask

  initial begin
    int tags4[5];
    clear_inputs();
    rst = 1'b1;
    model_reset();

    // single request
    do_reset();
    bus.req_valid = 4'b0001; set_req(0, 4, 6); bus.resp_ready = 1'b1;
    step();
    bus.req_valid = '0;
    repeat (3) step();
    check("single_count", 64'(obs_tag.size()), 64'd1);
    check_obs("single", 0, 0, 10);

    // two requesters continuously valid alternate from 0
    do_reset();
    bus.req_valid = 4'b0011; set_req(0, 2, 5); set_req(1, 5, 8); bus.resp_ready = 1'b1;
    repeat (9) step();
    bus.req_valid = '0;
    check("alt_count", 64'(obs_tag.size()), 64'd3);
    check_obs("alt0", 0, 0, 7);
    check_obs("alt1", 1, 1, 13);
    check_obs("alt2", 2, 0, 7);

    // backpressure with wrap-around sum; a competing request is held off
    obs_tag.delete(); obs_data.delete();
    bus.req_valid = 4'b0010; set_req(1, 32'hFFFF_FFFF, 1); bus.resp_ready = 1'b0;
    step();
    bus.req_valid = '0;
    step();
    bus.req_valid = 4'b0001;
    repeat (5) step();
    bus.req_valid = '0; bus.resp_ready = 1'b1;
    repeat (2) step();
    check("bp_count", 64'(obs_tag.size()), 64'd1);
    check_obs("bp", 0, 1, 0);

    // four-way fairness and pointer wrap
    do_reset();
    bus.req_valid = 4'b1111; bus.resp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, W'(i), W'(10 * i));
    repeat (15) step();
    bus.req_valid = '0;
    tags4 = '{0, 1, 2, 3, 0};
    check("rr_count", 64'(obs_tag.size()), 64'd5);
    for (int i = 0; i < 5; i++) check_obs("rr", i, tags4[i], W'(11 * tags4[i]));

    // asynchronous reset in the middle of RESP
    bus.req_valid = 4'b0001; set_req(0, 1, 2); bus.resp_ready = 1'b0;
    step();
    bus.req_valid = '0;
    repeat (2) step();
    #3 rst = 1'b1;
    #1;
    check("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_resp_data", 64'(bus.resp_data), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    obs_tag.delete(); obs_data.delete();
    bus.req_valid = 4'b0011; set_req(0, 100, 1); set_req(1, 200, 2); bus.resp_ready = 1'b1;
    step();
    bus.req_valid = '0;
    repeat (3) step();
    check("post_rst_count", 64'(obs_tag.size()), 64'd1);
    check_obs("post_rst", 0, 0, 101);

    // request raised only while busy, then withdrawn
    obs_tag.delete(); obs_data.delete();
    bus.req_valid = 4'b0100; set_req(2, 3, 4); bus.resp_ready = 1'b0;
    step();
    bus.req_valid = '0;
    repeat (2) step();
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    bus.resp_ready = 1'b1;
    repeat (4) step();
    check("withdraw_count", 64'(obs_tag.size()), 64'd1);
    check_obs("withdraw", 0, 2, 7);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one instance of the existing 32-bit combinational `adder` (ports: data1, data2, output) between NUM_REQ requesters.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Operands are latched at grant, and the sum is registered one cycle later.
- The result is returned with a one-hot response tag, held until the consumer accepts it.
- Sits between the PC-increment / branch-target / ALU-address users and the single shared adder.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 32, operand/result width. Must match `adder` width.
- IDW, 1, width of grant_id; must satisfy 2^IDW >= NUM_REQ.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant; request i is accepted on a cycle where req_valid[i] && req_ready[i].
- resp_valid  output  NUM_REQ  one-hot; result belongs to requester i.
- resp_data  output  WIDTH  registered sum.
- resp_ready  input  1  consumer accepts the response.
- grant_id  output  IDW  index of the requester currently owning the adder.
- busy  output  1  high in CALC or RESP.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_data=0, grant_id=0, busy=0, operand registers=0.
- IDLE:
  - If any req_valid, select the first valid index searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Drive req_ready combinationally one-hot for that index only. All other bits of req_ready are 0.
  - On accept: latch req_a/req_b slices into op_a/op_b, set grant_id=index, set rr_ptr=(index+1) mod NUM_REQ, go to CALC.
  - No valid: req_ready=0, remain IDLE.
- CALC (exactly 1 cycle):
  - resp_data <= adder(op_a, op_b); go to RESP.
  - Arithmetic is modulo 2^WIDTH. Carry-out is discarded, e.g. 0xFFFFFFFF+1=0.
- RESP:
  - resp_valid = one-hot(grant_id). resp_data is held stable.
  - When resp_ready=1, the response completes; go to IDLE.
  - When resp_ready=0, remain in RESP with all outputs unchanged (backpressure).
- Latency: accept at cycle T; resp_valid is high from cycle T+2. Maximum throughput is one operation per 3 cycles with resp_ready tied high.
- req_ready is 0 in CALC and RESP. Requests must hold valid/operands until accepted. Requesters not granted are unaffected.
- A requester may drop req_valid before grant. The arbiter evaluates only current-cycle valid, with no latching of pending requests.
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.
- Simultaneous requests: the rr_ptr order decides the grant. With NUM_REQ=2 and both valid continuously, grants alternate 0,1,0,1 starting at 0 after reset.
- Reset mid-operation (CALC or RESP): the in-flight result is dropped. resp_valid falls immediately, state returns to IDLE, rr_ptr=0.
- Wrap: rr_ptr increments from NUM_REQ-1 to 0.
- Only one `adder` instance is permitted. It is fed exclusively from op_a/op_b registers.

Test Plan:
1. Reset then single request: req0 a=4, b=6, resp_ready=1 -> req_ready[0] high in the accept cycle; two cycles later resp_valid=2'b01, resp_data=10; then IDLE.
2. Both requesters valid continuously: req0 (2,5), req1 (5,8), resp_ready=1 -> first response 2'b01/7, then 2'b10/13, then 2'b01/7; grant_id alternates 0,1,0.
3. Backpressure: req1 (0xFFFFFFFF, 1), resp_ready=0 for 5 cycles -> resp_valid=2'b10, resp_data=0 held stable; req_ready=00 throughout; releases one cycle after resp_ready=1.
4. Fairness/wrap with NUM_REQ=4: all valid, operands (i, 10*i) -> grant order 0,1,2,3,0, sums 0,11,22,33,0.
5. Async reset asserted mid-RESP (not on a clock edge) -> resp_valid and busy drop immediately; after release, a new request from req1 is granted per rr_ptr=0 search (req0 first if also valid).
6. Request withdrawn: req0 valid for 1 cycle while the block is in RESP, then dropped -> no grant to req0, no spurious response.
